// File: rtl/upload_arb_pkg.sv
// upload_arb_pkg: shared types and constants for the upload arbiter.
// Holds the arbiter state encoding, the 16-bit FIFO entry layout
// ({source tag, data byte}) and the well-known source tag values.
package upload_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    localparam int ENTRY_W = 16;

    localparam logic [7:0] SRC_ID_UART = 8'h01;
    localparam logic [7:0] SRC_ID_SPI  = 8'h03;
    localparam logic [7:0] SRC_ID_I2C  = 8'h04;

    // Tag lives in the upper byte so a raw entry reads as {tag, data}.
    typedef struct packed {
        logic [7:0] source;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/upload_fifo.sv
// upload_fifo: synchronous show-ahead FIFO with full/empty/count.
// The head entry is visible on head_data whenever the FIFO is not empty;
// pop consumes it. DEPTH must be a power of two (>= 2) so the pointers
// wrap naturally. A push while full is accepted only alongside a pop.
module upload_fifo
    import upload_arb_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign count     = count_reg;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr_reg];

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push+pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/upload_arbiter.sv
// upload_arbiter: round-robin packet arbiter merging NUM_SRC byte streams
// into one tagged stream through a show-ahead FIFO.
// A source owns the grant for a whole packet (while its src_req is high);
// after release the FIFO drains before the next arbitration round.
// Optional feature macro: UPLOAD_ARB_TIMEOUT_EN adds a grant watchdog of
// TIMEOUT_CYCLES idle cycles that forces a drain and flags err_drop; a
// timed-out source is not re-granted until it drops src_req.
module upload_arbiter
    import upload_arb_pkg::*;
#(
    parameter int NUM_SRC        = 3,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [8*NUM_SRC-1:0] src_source,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 merged_req,
    output logic                 merged_valid,
    output logic [7:0]           merged_data,
    output logic [7:0]           merged_source,
    input  logic                 merged_ready,
    output logic [2:0]           grant_id,
    output logic                 err_drop
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_t       state_reg, state_next;
    logic [2:0]       grant_id_reg, grant_id_next;
    logic [2:0]       last_grant_reg, last_grant_next;
    logic             err_drop_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    entry_t           head_entry;
    entry_t           push_entry;
    logic             push;
    logic             pop;

    logic             g_req;
    logic             g_valid;
    logic [7:0]       g_data;
    logic [7:0]       g_source;
    logic [NUM_SRC-1:0] eligible_req;
    logic             rr_found;
    logic [2:0]       rr_winner;
    logic             drain_req;
    logic             drop_any;

    // Per-source accept: only the owner sees ready, and only with room.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign src_ready[gi] = (state_reg == ARB_GRANT) &&
                                   (grant_id_reg == 3'(gi)) && !fifo_full;
        end
    endgenerate

    // Select the granted source's request/strobe/byte/tag.
    always_comb begin
        g_req    = 1'b0;
        g_valid  = 1'b0;
        g_data   = 8'h00;
        g_source = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id_reg == 3'(i)) begin
                g_req    = src_req[i];
                g_valid  = src_valid[i];
                g_data   = src_data[8*i +: 8];
                g_source = src_source[8*i +: 8];
            end
        end
    end

    assign push       = g_valid && (|src_ready);
    assign pop        = merged_valid && merged_ready;
    assign push_entry = '{source: g_source, data: g_data};
    assign drop_any   = |(src_valid & ~src_ready);

`ifdef UPLOAD_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0]    to_cnt_reg;
    logic [NUM_SRC-1:0] blocked_reg;
    logic               timeout_fire;

    assign timeout_fire = (state_reg == ARB_GRANT) && !push &&
                          (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign eligible_req = src_req & ~blocked_reg;
    assign drain_req    = !g_req || timeout_fire;

    // Watchdog counts idle grant cycles; blocks a timed-out source until
    // its request has been seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg  <= '0;
            blocked_reg <= '0;
        end else begin
            if (state_reg != ARB_GRANT || push || timeout_fire) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
            blocked_reg <= (blocked_reg & src_req) |
                           (timeout_fire ? (NUM_SRC'(1) << grant_id_reg) : '0);
        end
    end
`else
    assign eligible_req = src_req;
    assign drain_req    = !g_req;
`endif

    // Round-robin search starting just after the previous owner.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_grant_reg;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!rr_found && eligible_req[i] &&
                    ((int'(last_grant_reg) + k) % NUM_SRC) == i) begin
                    rr_found  = 1'b1;
                    rr_winner = 3'(i);
                end
            end
        end
    end

    // Next-state logic: arbitrate, hold grant for the packet, then drain.
    always_comb begin
        state_next      = state_reg;
        grant_id_next   = grant_id_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (rr_found) begin
                    grant_id_next = rr_winner;
                    state_next    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (drain_req) begin
                    state_next = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (fifo_count == '0) begin
                    last_grant_next = grant_id_reg;
                    state_next      = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // State, grant bookkeeping and the sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            grant_id_reg   <= 3'd0;
            last_grant_reg <= 3'(NUM_SRC - 1);
            err_drop_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_id_reg   <= grant_id_next;
            last_grant_reg <= last_grant_next;
`ifdef UPLOAD_ARB_TIMEOUT_EN
            err_drop_reg   <= err_drop_reg | drop_any | timeout_fire;
`else
            err_drop_reg   <= err_drop_reg | drop_any;
`endif
        end
    end

    upload_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_entry    = entry_t'(fifo_head);
    assign merged_req    = (state_reg != ARB_IDLE);
    assign merged_valid  = !fifo_empty;
    // Uninitialised storage is masked so outputs read zero while empty.
    assign merged_data   = fifo_empty ? 8'h00 : head_entry.data;
    assign merged_source = fifo_empty ? 8'h00 : head_entry.source;
    assign grant_id      = grant_id_reg;
    assign err_drop      = err_drop_reg;

endmodule

// File: tb/tb_upload_arbiter.sv
// tb_upload_arbiter: directed bench for upload_arbiter (NUM_SRC=3,
// FIFO_DEPTH=16, TIMEOUT_CYCLES=8). Inputs change and outputs are
// sampled on the falling clock edge. The watchdog scenario runs only
// when UPLOAD_ARB_TIMEOUT_EN is defined.
module tb_upload_arbiter;
    import upload_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  src_req;
    logic [2:0]  src_valid;
    logic [23:0] src_data;
    logic [23:0] src_source;
    logic [2:0]  src_ready;
    logic        merged_req;
    logic        merged_valid;
    logic [7:0]  merged_data;
    logic [7:0]  merged_source;
    logic        merged_ready;
    logic [2:0]  grant_id;
    logic        err_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    upload_arbiter #(
        .NUM_SRC        (3),
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_req       (src_req),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_source    (src_source),
        .src_ready     (src_ready),
        .merged_req    (merged_req),
        .merged_valid  (merged_valid),
        .merged_data   (merged_data),
        .merged_source (merged_source),
        .merged_ready  (merged_ready),
        .grant_id      (grant_id),
        .err_drop      (err_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put(input int s, input logic v, input logic [7:0] d, input logic [7:0] t);
        src_valid[s]        = v;
        src_data[8*s +: 8]  = d;
        src_source[8*s +: 8] = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_req = '0;
        src_valid = '0;
        #1;
        chk("rst_merged_req", merged_req, 0);
        chk("rst_merged_valid", merged_valid, 0);
        chk("rst_src_ready", src_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One packet from source s: n bytes starting at base, delivered and
    // checked in order. With stall>0 the sink is held off until that
    // cycle, at which point the FIFO is expected to be full.
    task automatic xfer(input int s, input int n, input logic [7:0] base,
                        input logic [7:0] tag, input int stall);
        int sent = 0;
        int rcv  = 0;
        logic [7:0] exp_b;
        merged_ready = (stall == 0);
        src_req[s] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (stall > 0 && c == stall) begin
                chk("bp_ready_low", src_ready[s], 0);
                chk("bp_sent_16", sent, 16);
                chk("bp_err_drop", err_drop, 0);
                chk("bp_valid", merged_valid, 1);
                merged_ready = 1'b1;
            end
            if (merged_valid && merged_ready) begin
                exp_b = base + 8'(rcv);
                $display("txn src=%0d idx=%0d data=%02h tag=%02h", s, rcv, merged_data, merged_source);
                chk("xfer_data", merged_data, exp_b);
                chk("xfer_tag", merged_source, tag);
                rcv++;
            end
            if (src_ready[s] && sent < n) begin
                put(s, 1'b1, base + 8'(sent), tag);
                sent++;
            end else begin
                put(s, 1'b0, 8'h00, 8'h00);
            end
            if (rcv == n) break;
            tick();
        end
        chk("xfer_count", rcv, n);
        put(s, 1'b0, 8'h00, 8'h00);
        src_req[s] = 1'b0;
        tick();
        tick();
        chk("xfer_req_low", merged_req, 0);
        chk("xfer_empty", merged_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        src_req = '0;
        src_valid = '0;
        src_data = '0;
        src_source = '0;
        merged_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_merged_req", merged_req, 0);
        chk("rst_merged_valid", merged_valid, 0);
        chk("rst_merged_data", merged_data, 8'h00);
        chk("rst_merged_source", merged_source, 8'h00);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err_drop", err_drop, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source, three bytes with SPI tag
        src_req[1] = 1'b1;
        tick();
        chk("s1_grant", grant_id, 1);
        chk("s1_ready", src_ready, 3'b010);
        chk("s1_req", merged_req, 1);
        put(1, 1'b1, 8'hA1, SRC_ID_SPI);
        tick();
        chk("s1_latency_valid", merged_valid, 1);
        chk("s1_b0", merged_data, 8'hA1);
        chk("s1_tag", merged_source, 8'h03);
        put(1, 1'b1, 8'hA2, SRC_ID_SPI);
        tick();
        chk("s1_b1", merged_data, 8'hA2);
        put(1, 1'b1, 8'hA3, SRC_ID_SPI);
        tick();
        chk("s1_b2", merged_data, 8'hA3);
        src_req[1] = 1'b0;
        put(1, 1'b0, 8'h00, 8'h00);
        tick();
        chk("s1_drain_valid", merged_valid, 0);
        chk("s1_drain_req", merged_req, 1);
        tick();
        chk("s1_req_fall", merged_req, 0);
        chk("s1_err_drop", err_drop, 0);

        // Contention between sources 0 and 2
        do_reset();
        src_req = 3'b101;
        tick();
        chk("rr_first_grant", grant_id, 0);
        chk("rr_first_ready", src_ready, 3'b001);
        put(0, 1'b1, 8'h10, SRC_ID_UART);
        tick();
        put(0, 1'b0, 8'h00, 8'h00);
        src_req[0] = 1'b0;
        chk("rr_byte", merged_data, 8'h10);
        tick();
        chk("rr_drain_req", merged_req, 1);
        chk("rr_drain_empty", merged_valid, 0);
        tick();
        chk("rr_idle", merged_req, 0);
        src_req[0] = 1'b1;
        tick();
        chk("rr_second_grant", grant_id, 2);
        chk("rr_second_ready", src_ready, 3'b100);
        src_req[2] = 1'b0;
        tick();
        tick();
        tick();
        chk("rr_third_grant", grant_id, 0);
        chk("rr_third_ready", src_ready, 3'b001);

        // Illegal strobe from a non-owner
        put(2, 1'b1, 8'h55, SRC_ID_I2C);
        tick();
        chk("ill_err_drop", err_drop, 1);
        chk("ill_not_pushed", merged_valid, 0);
        put(2, 1'b0, 8'h00, 8'h00);
        src_req[0] = 1'b0;
        tick();
        tick();
        chk("ill_never_delivered", merged_valid, 0);
        chk("ill_idle", merged_req, 0);

        // Backpressure: 20 bytes into a 16-deep FIFO
        do_reset();
        chk("bp_err_clear", err_drop, 0);
        xfer(0, 20, 8'h20, SRC_ID_UART, 25);
        chk("bp_err_final", err_drop, 0);

        // Reset in the middle of a buffered packet
        merged_ready = 1'b0;
        src_req[1] = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("mid_ready", src_ready[1], 1);
            put(1, 1'b1, 8'h80 + 8'(k), SRC_ID_SPI);
            tick();
        end
        put(1, 1'b0, 8'h00, 8'h00);
        src_req[1] = 1'b0;
        chk("mid_buffered", merged_valid, 1);
        chk("mid_head", merged_data, 8'h80);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", merged_valid, 0);
        chk("mid_rst_idle", merged_req, 0);
        chk("mid_rst_data", merged_data, 8'h00);
        chk("mid_rst_ready", src_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(2, 2, 8'h61, SRC_ID_I2C, 0);

`ifdef UPLOAD_ARB_TIMEOUT_EN
        // Grant watchdog: source 1 requests but never sends
        do_reset();
        src_req[1] = 1'b1;
        tick();
        chk("to_grant", grant_id, 1);
        src_req[0] = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("to_still_granted", src_ready, 3'b010);
        tick();
        chk("to_released", src_ready, 3'b000);
        chk("to_err_drop", err_drop, 1);
        tick();
        tick();
        chk("to_next_grant", grant_id, 0);
        chk("to_next_ready", src_ready, 3'b001);
        src_req = '0;
        tick();
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/upload_arbiter.md
UPLOAD_ARBITER -- requirements
Module: upload_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of requesting handlers (2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: buffer entries, power of two.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: grant watchdog limit; used only under REQ-026.
REQ-004 SHALL have: clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have: src_req  in  NUM_SRC  per-source packet request, held high for the whole packet.
REQ-007 SHALL have: src_valid  in  NUM_SRC  per-source byte strobe.
REQ-008 SHALL have: src_data  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i].
REQ-009 SHALL have: src_source  in  8*NUM_SRC  per-source tag byte; same packing.
REQ-010 SHALL have: src_ready  out  NUM_SRC  per-source accept.
REQ-011 SHALL have: merged_req, merged_valid  out  1 each; merged_data, merged_source  out  8 each; merged_ready  in  1.
REQ-012 SHALL have: grant_id  out  3  current owner index; err_drop  out  1  sticky dropped-byte flag.

Function
REQ-013 SHALL implement states ARB_IDLE, ARB_GRANT, ARB_DRAIN.
REQ-014 ARB_IDLE: if any src_req is high, SHALL pick the winner round-robin, starting at (last_grant+1) mod NUM_SRC; load grant_id; enter ARB_GRANT next cycle.
REQ-015 ARB_GRANT: grant SHALL be locked while src_req[grant_id] is high; other sources SHALL see src_ready=0.
REQ-016 src_ready[i] SHALL be combinational: (state==ARB_GRANT) && (grant_id==i) && !fifo_full.
REQ-017 A byte SHALL be pushed when src_valid[g] && src_ready[g], storing {src_source[g], src_data[g]} as one 16-bit entry.
REQ-018 If src_valid[i] is high while src_ready[i] is low, the byte SHALL be discarded and err_drop set. err_drop clears only on reset.
REQ-019 When src_req[grant_id] falls in ARB_GRANT, SHALL enter ARB_DRAIN. A src_valid in that same cycle SHALL still be pushed if ready.
REQ-020 ARB_DRAIN: when the FIFO is empty, SHALL record last_grant=grant_id and return to ARB_IDLE.
REQ-021 merged_req SHALL be high in ARB_GRANT and ARB_DRAIN, and low in ARB_IDLE.
REQ-022 merged_valid SHALL equal !fifo_empty. merged_data and merged_source SHALL show the FIFO head (show-ahead). Pop on merged_valid && merged_ready.
REQ-023 Latency: a byte accepted at edge t SHALL appear on merged_valid at t+1 when the FIFO was empty.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged, including at full. Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-025 On rst_n low, asynchronously:
- state=ARB_IDLE
- grant_id=0; last_grant=NUM_SRC-1, so source 0 wins first
- FIFO empty; err_drop=0
- merged_req=0, merged_valid=0, merged_data=8'h00, merged_source=8'h00, src_ready=0
- reset mid-packet SHALL discard buffered bytes.

Configuration
REQ-026 With UPLOAD_ARB_TIMEOUT_EN defined, a counter SHALL run in ARB_GRANT.
- Clears on each accepted byte.
- At TIMEOUT_CYCLES without a byte, forces ARB_DRAIN and sets err_drop.
- The same source SHALL NOT be re-granted until its src_req has been observed low.
REQ-027 Without UPLOAD_ARB_TIMEOUT_EN, no counter logic SHALL exist, and the grant holds indefinitely while src_req is high.

Structure
REQ-028 Package upload_arb_pkg SHALL hold:
- state encodings
- entry width (16)
- source tag constants SRC_ID_UART=8'h01, SRC_ID_SPI=8'h03, SRC_ID_I2C=8'h04.
REQ-029 The FIFO SHALL be a sub-module upload_fifo: synchronous, show-ahead, parameterised width and depth, with full/empty/count.

Verification
REQ-030 Single source: src 1 sends 3 bytes 0xA1,0xA2,0xA3 with tag 0x03, merged_ready=1 -> merged outputs carry the same bytes in order with tag 0x03; merged_req falls one cycle after the last pop.
REQ-031 Contention: src 0 and src 2 both raise req after reset -> src 0 is served first. On the next contention between src 0 and src 2, src 2 wins (round-robin).
REQ-032 Backpressure: merged_ready=0, 20 bytes offered with depth 16 -> src_ready drops after the 16th push and err_drop stays 0. Release merged_ready -> all 20 bytes delivered.
REQ-033 Illegal valid: src 2 pulses valid 0x55 while src 0 is granted -> byte not delivered; err_drop=1.
REQ-034 Reset mid-packet: assert rst_n after 4 of 8 bytes -> merged_valid=0 and state ARB_IDLE immediately; the next packet is delivered cleanly.
REQ-035 With UPLOAD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: src 1 holds req with no valid -> grant released after 8 cycles, err_drop=1, src 0 granted next.
